// File: rtl/conv_window_buffer.sv
// Streaming 3x3 window generator: two line buffers plus a shifting 3x3 register window.
// One cycle from the completing pixel to win_valid; input stalls while a window is held unconsumed.
module conv_window_buffer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_pixel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [71:0] win_out,
  output logic        win_valid,
  input  logic        win_ready,
  output logic        win_last
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    lb0 [WIDTH];
  logic [7:0]    lb1 [WIDTH];
  logic [7:0]    win [9];
  logic          accept;
  logic          col_end;
  logic          row_end;
  logic          emit;

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == CW'(WIDTH - 1));
  assign row_end  = (row == RW'(HEIGHT - 1));
  assign emit     = (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers are never reset; every entry is rewritten before a window can use it.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb0[col];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb1[col];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= in_pixel;
      // Columns 0/1 still shift the window but hold stale left columns, so they never emit.
      win_valid <= emit;
      win_last  <= emit && row_end && col_end;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign win_out[8*k +: 8] = win[k];
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer: an 8x8 and a 3x3 instance driven from image-array reference windows.
module tb_conv_window_buffer;

  logic        clk;
  logic        rst;
  logic [7:0]  a_pix, b_pix;
  logic        a_iv, a_ir, a_wv, a_wr, a_wl;
  logic        b_iv, b_ir, b_wv, b_wr, b_wl;
  logic [71:0] a_win, b_win;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  logic [7:0]  img [64][64];
  logic [72:0] exp_a[$], exp_b[$], log_a[$], log_b[$];
  int          logc_a[$];

  conv_window_buffer #(.WIDTH(8), .HEIGHT(8)) dut_a (
    .clk(clk), .rst(rst), .in_pixel(a_pix), .in_valid(a_iv), .in_ready(a_ir),
    .win_out(a_win), .win_valid(a_wv), .win_ready(a_wr), .win_last(a_wl));

  conv_window_buffer #(.WIDTH(3), .HEIGHT(3)) dut_b (
    .clk(clk), .rst(rst), .in_pixel(b_pix), .in_valid(b_iv), .in_ready(b_ir),
    .win_out(b_win), .win_valid(b_wv), .win_ready(b_wr), .win_last(b_wl));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  function automatic logic [71:0] mkw(input int b, input int st);
    logic [71:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(b + st*i + j);
    return w;
  endfunction

  function automatic logic [72:0] at(input logic [72:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction

  task automatic send(input bit sel, input logic [7:0] p, input bit bub, output bit ok);
    int  n;
    bit  acc;
    if (bub) begin
      while ($urandom_range(1, 0) == 1) begin
        if (sel) b_iv = 1'b0; else a_iv = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (sel) begin b_iv = 1'b1; b_pix = p; end
    else     begin a_iv = 1'b1; a_pix = p; end
    n = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = sel ? b_ir : a_ir;
      @(posedge clk); #1;
      n++;
    end
    ok = acc;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end
  endtask

  // Reference: the image is kept as a 2-D array; each window is read straight out of it.
  task automatic frame(input bit sel, input int w, input int h, input bit rnd,
                       input int base, input bit bub, input int npix);
    int          cnt;
    bit          ok;
    logic [7:0]  p;
    logic [71:0] win;
    cnt = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (cnt < npix) begin
          p = rnd ? 8'($urandom) : 8'(w*r + c + base);
          img[r][c] = p;
          send(sel, p, bub, ok);
          cnt++;
          if (ok && r == 2 && c == 2) acc_cyc = cyc;
          if (ok && r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                win[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
            if (sel) exp_b.push_back({(r == h-1 && c == w-1), win});
            else     exp_a.push_back({(r == h-1 && c == w-1), win});
          end
        end
      end
    end
    if (sel) b_iv = 1'b0; else a_iv = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while ((sel ? exp_b.size() : exp_a.size()) != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk(sel ? "b_drain" : "a_drain", 73'(sel ? exp_b.size() : exp_a.size()), 73'(0));
  endtask

  task automatic clear_logs();
    log_a.delete();
    logc_a.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nlast;
    bit done;
    rst = 1'b1;
    a_pix = '0; a_iv = 1'b0; a_wr = 1'b1;
    b_pix = '0; b_iv = 1'b0; b_wr = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst && a_wv && a_wr) begin
          log_a.push_back({a_wl, a_win});
          logc_a.push_back(cyc);
          if (exp_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_extra_window actual=%h required=none", {a_wl, a_win});
          end else chk("a_window", {a_wl, a_win}, exp_a.pop_front());
        end
        if (!rst && b_wv && b_wr) begin
          log_b.push_back({b_wl, b_win});
          if (exp_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_extra_window actual=%h required=none", {b_wl, b_win});
          end else chk("b_window", {b_wl, b_win}, exp_b.pop_front());
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_win_valid", 73'(a_wv), 73'(0));
    chk("rst_win_last",  73'(a_wl), 73'(0));
    chk("rst_win_out",   73'(a_win), 73'(0));
    chk("rst_in_ready",  73'(a_ir), 73'(1));
    chk("rst_b_valid",   73'(b_wv), 73'(0));
    @(posedge clk); #1;

    // Ramp frame, back-to-back, always ready
    clear_logs();
    frame(0, 8, 8, 0, 0, 0, 64);
    drain(0);
    chk("ramp_count", 73'(log_a.size()), 73'(36));
    chk("ramp_first", at(log_a, 0), {1'b0, mkw(0, 8)});
    chk("ramp_latency", 73'(logc_a.size() > 0 ? logc_a[0] : -1), 73'(acc_cyc));
    chk("ramp_last", at(log_a, 35), {1'b1, mkw(45, 8)});
    nlast = 0;
    foreach (log_a[i]) if (log_a[i][72]) nlast++;
    chk("ramp_last_flags", 73'(nlast), 73'(1));

    // Backpressure on the first window
    clear_logs();
    a_wr = 1'b0;
    fork
      frame(0, 8, 8, 0, 0, 0, 64);
      begin
        int n;
        logic [71:0] held;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_wv && n < 300);
        held = a_win;
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          chk("bp_in_ready", 73'(a_ir), 73'(0));
          chk("bp_win_stable", 73'(a_win), 73'(held));
          chk("bp_win_valid", 73'(a_wv), 73'(1));
        end
        @(posedge clk); #1;
        a_wr = 1'b1;
      end
    join
    drain(0);
    chk("bp_first", at(log_a, 0), {1'b0, mkw(0, 8)});
    chk("bp_second", at(log_a, 1), {1'b0, mkw(1, 8)});
    chk("bp_count", 73'(log_a.size()), 73'(36));

    // Input bubbles at ~50% duty
    clear_logs();
    frame(0, 8, 8, 0, 0, 1, 64);
    drain(0);
    chk("bub_count", 73'(log_a.size()), 73'(36));
    chk("bub_last", at(log_a, 35), {1'b1, mkw(45, 8)});

    // Two frames back-to-back, second offset by 100
    clear_logs();
    frame(0, 8, 8, 0, 0, 0, 64);
    frame(0, 8, 8, 0, 100, 0, 64);
    drain(0);
    chk("b2b_count", 73'(log_a.size()), 73'(72));
    chk("b2b_f1_last", at(log_a, 35), {1'b1, mkw(45, 8)});
    chk("b2b_f2_first", at(log_a, 36), {1'b0, mkw(100, 8)});

    // Reset mid-frame after 30 pixels
    frame(0, 8, 8, 0, 0, 0, 30);
    rst = 1'b1;
    exp_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_win_valid", 73'(a_wv), 73'(0));
    @(posedge clk); #1;
    clear_logs();
    frame(0, 8, 8, 0, 0, 0, 64);
    drain(0);
    chk("midrst_count", 73'(log_a.size()), 73'(36));
    chk("midrst_first", at(log_a, 0), {1'b0, mkw(0, 8)});

    // Random pixels, random bubbles, random downstream ready
    clear_logs();
    done = 1'b0;
    fork
      begin
        frame(0, 8, 8, 1, 0, 1, 64);
        drain(0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          a_wr = ($urandom_range(3, 0) != 0);
        end
        a_wr = 1'b1;
      end
    join
    chk("rand_count", 73'(log_a.size()), 73'(36));

    // Minimum 3x3 image
    frame(1, 3, 3, 0, 1, 0, 9);
    drain(1);
    chk("min_count", 73'(log_b.size()), 73'(1));
    chk("min_window", at(log_b, 0), {1'b1, mkw(1, 3)});

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
